// File: rtl/multiword_add_pkg.sv
// Shared types and defaults for the sliced multi-word adder.
// Ports: none (package). Provides the FSM state type, default slice geometry,
//        and the slice-counter width helper used by the top module.
package multiword_add_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int SLICE_W_DEF = 16;
  localparam int NSLICES_DEF = 4;

  // Counter must index slices 0..n-1; keep at least one bit so n=1/2 still work.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multiword_add_seq_if.sv
// Operand/result handshake bundle for multiword_add_seq.
// Ports: in_valid/in_ready + a, b, cin, sub (operand side);
//        out_valid/out_ready + sum, cout, ovf (result side).
interface multiword_add_seq_if
  import multiword_add_pkg::*;
#(
  parameter int WIDTH = SLICE_W_DEF * NSLICES_DEF
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Producer/consumer side.
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/NBitCellAdder.sv
// NBIT-wide combinational carry-lookahead adder cell (parallel-prefix carries).
// Ports: a, b, cin in; sum, cout out. Purely combinational, no clock.
module NBitCellAdder #(
  parameter int NBIT = 16
) (
  input  logic [NBIT-1:0] a,
  input  logic [NBIT-1:0] b,
  input  logic            cin,
  output logic [NBIT-1:0] sum,
  output logic            cout
);

  localparam int LV = (NBIT > 1) ? $clog2(NBIT) : 1;

  logic [NBIT-1:0] g;
  logic [NBIT-1:0] p;
  logic [NBIT-1:0] gc;
  logic [NBIT-1:0] pc;
  logic [NBIT-1:0] gn;
  logic [NBIT-1:0] pn;
  logic [NBIT:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Kogge-Stone prefix: after LV levels gc[i]/pc[i] are group generate and
  // propagate over bits [i:0].
  always_comb begin
    gc = g;
    pc = p;
    gn = g;
    pn = p;
    for (int l = 0; l < LV; l++) begin
      gn = gc;
      pn = pc;
      for (int i = 0; i < NBIT; i++) begin
        if (i >= (1 << l)) begin
          gn[i] = gc[i] | (pc[i] & gc[i - (1 << l)]);
          pn[i] = pc[i] & pc[i - (1 << l)];
        end
      end
      gc = gn;
      pc = pn;
    end
  end

  assign c    = {gc | (pc & {NBIT{cin}}), cin};
  assign sum  = p ^ c[NBIT-1:0];
  assign cout = c[NBIT];

endmodule

// File: rtl/multiword_add_seq.sv
// Adds/subtracts WIDTH-bit operands by stepping one shared SLICE_W-bit cell
// over NSLICES cycles, LS slice first, with a registered carry between slices.
// Ports: clk, rst (async, active-high), bus (slave handshake bundle), busy.
module multiword_add_seq
  import multiword_add_pkg::*;
#(
  parameter int SLICE_W = SLICE_W_DEF,
  parameter int NSLICES = NSLICES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  multiword_add_seq_if.slave  bus,
  output logic                busy
);

  localparam int WIDTH = SLICE_W * NSLICES;
  localparam int CW    = cnt_width(NSLICES);
  localparam logic [CW-1:0] LAST = CW'(NSLICES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic [SLICE_W-1:0] cell_a;
  logic [SLICE_W-1:0] cell_b;
  logic [SLICE_W-1:0] cell_sum;
  logic               cell_cout;
  logic               last_slice;
  logic               accept;

  assign accept     = (state == IDLE) && bus.in_valid;
  assign last_slice = (cnt == LAST);

  assign cell_a = a_reg[cnt*SLICE_W +: SLICE_W];
  assign cell_b = b_reg[cnt*SLICE_W +: SLICE_W];

  NBitCellAdder #(.NBIT(SLICE_W)) u_cell (
    .a    (cell_a),
    .b    (cell_b),
    .cin  (carry),
    .sum  (cell_sum),
    .cout (cell_cout)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (last_slice)    state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs; all return to reset values with the state register.
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    busy          = (state != IDLE);
  end

  // Datapath. Subtraction is folded in at accept time (B inverted, carry 1),
  // so RUN never needs to know which operation is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      carry  <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      a_reg <= bus.a;
      b_reg <= bus.sub ? ~bus.b : bus.b;
      carry <= bus.sub ? 1'b1 : bus.cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      sum_q[cnt*SLICE_W +: SLICE_W] <= cell_sum;
      carry                         <= cell_cout;
      if (last_slice) begin
        cout_q <= cell_cout;
        // Operand signs agree but the result sign differs.
        ovf_q  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                  (cell_sum[SLICE_W-1] != a_reg[WIDTH-1]);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule
